// File: rtl/osd_ctrl_pkg.sv
// rtl/osd_ctrl_pkg.sv - state encoding, opcodes and parameter defaults shared by the OSD command arbiter
package osd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LOAD,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE
  } osd_state_e;

  localparam logic [3:0] OSD_OP_WRITE  = 4'h2;
  localparam logic [3:0] OSD_OP_ENABLE = 4'h4;

  localparam int STROBE_LOW_DEF = 2;
  localparam int IDLE_GAP_DEF   = 4;
  localparam int TIMEOUT_DEF    = 1024;

  // Enable/disable commands carry the new enable state in bit 0.
  function automatic logic is_enable_cmd(input logic [7:0] cmd);
    return cmd[7:4] == OSD_OP_ENABLE;
  endfunction

endpackage

// File: rtl/osd_rr_arb2.sv
// rtl/osd_rr_arb2.sv - two-way round-robin pick; ptr=0 favours req[0] on a tie, ptr=1 favours req[1]
module osd_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/osd_cmd_arbiter.sv
// rtl/osd_cmd_arbiter.sv - arbitrates two command byte streams onto the OSD strobe bus; OSD_CMD_TIMEOUT_EN adds a LOAD stall timeout
module osd_cmd_arbiter
  import osd_ctrl_pkg::*;
#(
  parameter int STROBE_LOW = STROBE_LOW_DEF,
  parameter int IDLE_GAP   = IDLE_GAP_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       io_osd,
  output logic       io_strobe,
  output logic [7:0] io_din,
  output logic [1:0] grant,
  output logic       busy,
  output logic       osd_enabled,
  output logic       timeout_err
);

  localparam int DWELL_MAX = (STROBE_LOW > IDLE_GAP) ? STROBE_LOW : IDLE_GAP;
  localparam int CW        = $clog2(DWELL_MAX + 1);

  if (STROBE_LOW < 1 || IDLE_GAP < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("osd_cmd_arbiter: STROBE_LOW, IDLE_GAP and TIMEOUT must be at least 1");
  end

  osd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    owner_q;
  logic          ptr_q;
  logic          first_q;
  logic          last_q;
  logic [7:0]    din_q;
  logic          en_q;

  logic [1:0]    arb_gnt;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          capture;
  logic          stall;
  logic          timeout_hit;

  osd_rr_arb2 u_rr (
    .req ({req1_valid, req0_valid}),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  assign sel_valid = owner_q[1] ? req1_valid : req0_valid;
  assign sel_last  = owner_q[1] ? req1_last  : req0_last;
  assign sel_data  = owner_q[1] ? req1_data  : req0_data;
  assign capture   = (state_q == ST_LOAD) && sel_valid;
  assign stall     = (state_q == ST_LOAD) && !sel_valid;

  assign io_din      = din_q;
  assign osd_enabled = en_q;

`ifdef OSD_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_q;
  logic          terr_q;

  // Fires on the TIMEOUT-th consecutive stalled LOAD cycle.
  assign timeout_hit = stall && (stall_q == TW'(TIMEOUT - 1));
  assign timeout_err = terr_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= timeout_hit;
      if (capture || timeout_hit) begin
        stall_q <= '0;
      end else if (stall) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    io_osd     = 1'b0;
    io_strobe  = 1'b0;
    busy       = 1'b1;
    grant      = 2'b00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (arb_gnt != 2'b00) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        io_osd  = 1'b1;
        grant   = owner_q;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        io_osd     = 1'b1;
        grant      = owner_q;
        req0_ready = owner_q[0];
        req1_ready = owner_q[1];
        if (capture) begin
          state_d = ST_STROBE;
        end else if (timeout_hit) begin
          state_d = ST_RELEASE;
        end
      end
      ST_STROBE: begin
        io_osd    = 1'b1;
        io_strobe = 1'b1;
        grant     = owner_q;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        io_osd = 1'b1;
        grant  = owner_q;
        if (cnt_q == CW'(STROBE_LOW - 1)) begin
          state_d = last_q ? ST_RELEASE : ST_LOAD;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CW'(IDLE_GAP - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // cnt_q counts cycles spent in the current state; only HOLD and RELEASE look at it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      owner_q <= 2'b00;
      ptr_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      din_q   <= 8'h00;
      en_q    <= 1'b0;
    end else begin
      cnt_q <= (state_d == state_q) ? cnt_q + 1'b1 : '0;
      if (state_q == ST_IDLE && arb_gnt != 2'b00) begin
        owner_q <= arb_gnt;
        ptr_q   <= arb_gnt[0];
        first_q <= 1'b1;
      end
      if (capture) begin
        din_q   <= sel_data;
        last_q  <= sel_last;
        first_q <= 1'b0;
        if (first_q && is_enable_cmd(sel_data)) begin
          en_q <= sel_data[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// tb/tb_osd_cmd_arbiter.sv - self-checking bench for osd_cmd_arbiter
module tb_osd_cmd_arbiter;

  localparam int SL = 2;
  localparam int IG = 4;
  localparam int TO = 16;
  localparam int NTX = 12;

  typedef struct packed {
    logic [7:0] gap;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       en;
    logic [1:0] gnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] vld = 2'b00;
  logic [1:0] lst = 2'b00;
  logic [7:0] dat [2];
  logic       req0_ready, req1_ready;
  logic       io_osd, io_strobe, busy, osd_enabled, timeout_err;
  logic [7:0] io_din;
  logic [1:0] grant;

  int n_checks = 0;
  int n_errors = 0;

  beat_t bq [2][$];
  beat_t mq [2][$];
  logic [1:0] rdy_prev = 2'b00;
  logic [1:0] armed = 2'b00;
  int         wcnt [2];

  logic [7:0] mon_bytes [$];
  int         strobe_cyc [$];
  logic [1:0] f_owner [$];
  int         f_len [$];
  int         f_osd [$];
  logic       f_en [$];
  int         f_gap [$];
  int cyc = 0, cur_len = 0, osd_cnt = 0, rel_cnt = 0, bad_strobe = 0;
  int to_cycles = 0, to_pulses = 0, to_total = 0;
  logic prev_osd = 1'b0, prev_busy = 1'b0, prev_to = 1'b0;
  logic [1:0] cur_owner = 2'b00;

  osd_cmd_arbiter #(
    .STROBE_LOW (SL),
    .IDLE_GAP   (IG),
    .TIMEOUT    (TO)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (reset_n),
    .req0_valid  (vld[0]),
    .req0_ready  (req0_ready),
    .req0_data   (dat[0]),
    .req0_last   (lst[0]),
    .req1_valid  (vld[1]),
    .req1_ready  (req1_ready),
    .req1_data   (dat[1]),
    .req1_last   (lst[1]),
    .io_osd      (io_osd),
    .io_strobe   (io_strobe),
    .io_din      (io_din),
    .grant       (grant),
    .busy        (busy),
    .osd_enabled (osd_enabled),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Stream driver: a beat leaves its queue once valid was seen together with ready.
  initial begin
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    wcnt[0] = 0;
    wcnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (vld[n] && rdy_prev[n]) begin
          void'(bq[n].pop_front());
          armed[n] = 1'b0;
        end
        if (bq[n].size() == 0) begin
          vld[n] = 1'b0;
        end else begin
          if (!armed[n]) begin
            armed[n] = 1'b1;
            wcnt[n] = int'(bq[n][0].gap);
          end
          if (wcnt[n] > 0) begin
            vld[n] = 1'b0;
            wcnt[n]--;
          end else begin
            vld[n] = 1'b1;
            dat[n] = bq[n][0].data;
            lst[n] = bq[n][0].last;
          end
        end
      end
      rdy_prev = {req1_ready, req0_ready};
    end
  end

  // Bus observer: records strobed bytes, frames, release gaps and timeout pulses.
  always @(negedge clk) begin
    cyc++;
    if (timeout_err) begin
      to_cycles++;
      if (!prev_to) begin
        to_pulses++;
        to_total++;
      end
    end
    prev_to = timeout_err;
    if (!reset_n) begin
      prev_osd = 1'b0;
      prev_busy = 1'b0;
      cur_len = 0;
      osd_cnt = 0;
      rel_cnt = 0;
    end else begin
      if (io_osd && !prev_osd) begin
        cur_owner = grant;
        cur_len = 0;
        osd_cnt = 0;
      end
      if (io_osd) osd_cnt++;
      if (io_strobe) begin
        mon_bytes.push_back(io_din);
        strobe_cyc.push_back(cyc);
        cur_len++;
        if (!io_osd || grant != cur_owner) bad_strobe++;
      end
      if (prev_osd && !io_osd) begin
        f_owner.push_back(cur_owner);
        f_len.push_back(cur_len);
        f_osd.push_back(osd_cnt);
        f_en.push_back(osd_enabled);
        rel_cnt = 0;
      end
      if (busy && !io_osd && grant == 2'b00) rel_cnt++;
      if (prev_busy && !busy) f_gap.push_back(rel_cnt);
      prev_osd = io_osd;
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int n, input logic [7:0] d, input logic l, input int g);
    beat_t b;
    b.gap = 8'(g);
    b.last = l;
    b.data = d;
    bq[n].push_back(b);
  endtask

  task automatic clear_mon();
    #1;
    mon_bytes.delete();
    strobe_cyc.delete();
    f_owner.delete();
    f_len.delete();
    f_osd.delete();
    f_en.delete();
    f_gap.delete();
    to_cycles = 0;
    to_pulses = 0;
  endtask

  task automatic flush_drv();
    for (int n = 0; n < 2; n++) begin
      bq[n].delete();
      mq[n].delete();
    end
    armed = 2'b00;
    rdy_prev = 2'b00;
    vld = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    flush_drv();
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;
    clear_mon();
  endtask

  task automatic wait_gaps(input int k, input int budget, input string name);
    int t = 0;
    while (f_gap.size() < k && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, 32'(f_gap.size() >= k), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_io_osd"}, 32'(io_osd), 0);
    check({tag, "_io_strobe"}, 32'(io_strobe), 0);
    check({tag, "_io_din"}, 32'(io_din), 0);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'({req1_ready, req0_ready}), 0);
    check({tag, "_osd_enabled"}, 32'(osd_enabled), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  function automatic logic [7:0] mon_byte(input int k);
    logic [7:0] r;
    r = 8'hxx;
    if (k < mon_bytes.size()) r = mon_bytes[k];
    return r;
  endfunction

  function automatic int osd_cycles(input int nbytes);
    return 1 + nbytes * (2 + SL);
  endfunction

  initial begin
    vec_t tbl [7];
    logic [7:0] exp_b [8];
    logic [1:0] exp_o [4];
    int bad, rem [2], turn, o, fi, bi, len, flen_exp;
    logic en_m, first;
    beat_t b;
    logic [7:0] fb;

    tbl[0] = '{0, 8'h41, 1'b1, 2'b01};
    tbl[1] = '{0, 8'h40, 1'b0, 2'b01};
    tbl[2] = '{1, 8'h20, 1'b0, 2'b10};
    tbl[3] = '{1, 8'h45, 1'b1, 2'b10};
    tbl[4] = '{0, 8'h20, 1'b1, 2'b01};
    tbl[5] = '{1, 8'h4E, 1'b0, 2'b10};
    tbl[6] = '{0, 8'h21, 1'b0, 2'b01};

    repeat (3) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Single-byte transactions, one requester at a time.
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      push_beat(tbl[i].req, tbl[i].data, 1'b1, 0);
      wait_gaps(1, 100, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_owner", i), 32'(f_owner[0]), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_len", i), 32'(f_len[0]), 1);
      check($sformatf("tbl%0d_byte", i), 32'(mon_byte(0)), 32'(tbl[i].data));
      check($sformatf("tbl%0d_osd_cycles", i), 32'(f_osd[0]), 32'(osd_cycles(1)));
      check($sformatf("tbl%0d_release_gap", i), 32'(f_gap[0]), 32'(IG));
      check($sformatf("tbl%0d_osd_enabled", i), 32'(f_en[0]), 32'(tbl[i].en));
    end

    // Simultaneous requests, two transactions each, straight after reset.
    do_reset();
    push_beat(0, 8'h20, 1'b0, 0);
    push_beat(0, 8'h01, 1'b1, 0);
    push_beat(0, 8'h20, 1'b0, 0);
    push_beat(0, 8'h02, 1'b1, 0);
    push_beat(1, 8'h20, 1'b0, 0);
    push_beat(1, 8'h11, 1'b1, 0);
    push_beat(1, 8'h20, 1'b0, 0);
    push_beat(1, 8'h12, 1'b1, 0);
    wait_gaps(4, 300, "tie");
    exp_o = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_b = '{8'h20, 8'h01, 8'h20, 8'h11, 8'h20, 8'h02, 8'h20, 8'h12};
    for (int k = 0; k < 4; k++) check($sformatf("tie_owner%0d", k), 32'(f_owner[k]), 32'(exp_o[k]));
    for (int k = 0; k < 8; k++) check($sformatf("tie_byte%0d", k), 32'(mon_byte(k)), 32'(exp_b[k]));

    // Long burst from req1: 257 bytes with valid held high.
    clear_mon();
    push_beat(1, 8'h20, 1'b0, 0);
    for (int i = 0; i < 256; i++) push_beat(1, i[7:0], i == 255, 0);
    wait_gaps(1, 1500, "burst");
    check("burst_frames", 32'(f_owner.size()), 1);
    check("burst_owner", 32'(f_owner[0]), 32'(2'b10));
    check("burst_len", 32'(f_len[0]), 257);
    check("burst_strobes", 32'(strobe_cyc.size()), 257);
    check("burst_osd_cycles", 32'(f_osd[0]), 32'(osd_cycles(257)));
    bad = (mon_byte(0) === 8'h20) ? 0 : 1;
    for (int i = 0; i < 256; i++) if (mon_byte(i + 1) !== i[7:0]) bad++;
    check("burst_bytes", 32'(bad), 0);
    bad = 0;
    for (int k = 1; k < strobe_cyc.size(); k++) if (strobe_cyc[k] - strobe_cyc[k-1] != 2 + SL) bad++;
    check("burst_spacing", 32'(bad), 0);

    // Reset asserted while the third byte is on the bus.
    do_reset();
    for (int i = 0; i < 5; i++) push_beat(0, (i == 0) ? 8'h41 : 8'(8'hA0 + i), i == 4, 0);
    bad = 0;
    while (mon_bytes.size() < 3 && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    check("abort_reached_byte3", 32'(mon_bytes.size() >= 3), 1);
    #2;
    reset_n = 1'b0;
    flush_drv();
    #1;
    check_zero_outputs("abort");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    clear_mon();
    push_beat(0, 8'h41, 1'b0, 0);
    push_beat(0, 8'h99, 1'b1, 0);
    wait_gaps(1, 100, "after_abort");
    check("after_abort_owner", 32'(f_owner[0]), 32'(2'b01));
    check("after_abort_len", 32'(f_len[0]), 2);
    check("after_abort_byte0", 32'(mon_byte(0)), 32'h41);
    check("after_abort_byte1", 32'(mon_byte(1)), 32'h99);
    check("after_abort_osd_cycles", 32'(f_osd[0]), 32'(osd_cycles(2)));
    check("after_abort_osd_enabled", 32'(f_en[0]), 1);

`ifdef OSD_CMD_TIMEOUT_EN
    // req0 stalls after its second byte; req1 is waiting behind it.
    do_reset();
    push_beat(0, 8'h20, 1'b0, 0);
    push_beat(0, 8'h05, 1'b0, 0);
    push_beat(0, 8'h06, 1'b1, 30);
    push_beat(1, 8'h41, 1'b1, 0);
    wait_gaps(3, 400, "timeout");
    check("timeout_owner0", 32'(f_owner[0]), 32'(2'b01));
    check("timeout_owner1", 32'(f_owner[1]), 32'(2'b10));
    check("timeout_owner2", 32'(f_owner[2]), 32'(2'b01));
    check("timeout_len0", 32'(f_len[0]), 2);
    check("timeout_osd_cycles0", 32'(f_osd[0]), 32'(osd_cycles(2) + TO));
    check("timeout_pulses", 32'(to_pulses), 1);
    check("timeout_pulse_width", 32'(to_cycles), 1);
    check("timeout_byte2", 32'(mon_byte(2)), 32'h41);
    check("timeout_byte3", 32'(mon_byte(3)), 32'h06);
`endif

    // Random traffic on both requesters against an alternating-service model.
    do_reset();
    for (int n = 0; n < 2; n++) begin
      for (int t = 0; t < NTX; t++) begin
        len = int'($urandom_range(1, 4));
        case ($urandom_range(0, 3))
          0: fb = 8'h20;
          1: fb = 8'h40;
          2: fb = 8'h41;
          default: fb = 8'($urandom_range(0, 255));
        endcase
        for (int k = 0; k < len; k++) begin
          b.data = (k == 0) ? fb : 8'($urandom_range(0, 255));
          b.last = (k == len - 1);
          b.gap = (k == 0) ? 8'd0 : 8'($urandom_range(0, 6));
          bq[n].push_back(b);
          mq[n].push_back(b);
        end
      end
    end
    wait_gaps(2 * NTX, 6000, "rand");
    rem[0] = NTX;
    rem[1] = NTX;
    turn = 0;
    en_m = 1'b0;
    fi = 0;
    bi = 0;
    while (rem[0] + rem[1] > 0) begin
      o = (rem[0] > 0 && rem[1] > 0) ? turn : ((rem[0] > 0) ? 0 : 1);
      turn = 1 - o;
      rem[o]--;
      first = 1'b1;
      bad = 0;
      flen_exp = 0;
      do begin
        b = mq[o].pop_front();
        if (first && b.data[7:4] == 4'h4) en_m = b.data[0];
        first = 1'b0;
        if (mon_byte(bi) !== b.data) bad++;
        bi++;
        flen_exp++;
      end while (!b.last);
      check($sformatf("rand%0d_owner", fi), 32'(f_owner[fi]), 32'(2'b01 << o));
      check($sformatf("rand%0d_len", fi), 32'(f_len[fi]), 32'(flen_exp));
      check($sformatf("rand%0d_bytes", fi), 32'(bad), 0);
      check($sformatf("rand%0d_osd_enabled", fi), 32'(f_en[fi]), 32'(en_m));
      fi++;
    end
    check("rand_frames", 32'(f_owner.size()), 32'(2 * NTX));

`ifndef OSD_CMD_TIMEOUT_EN
    check("no_timeout_pulses", 32'(to_total), 0);
`endif
    check("strobe_framing", 32'(bad_strobe), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
